// File: rtl/run_ctrl_if.sv
// run_ctrl_if: control, status and progress signals between a sequencer and run_ctrl.
interface run_ctrl_if #(
    parameter int CNT_W = 32,
    parameter int RPT_W = 16
) ();
    logic             start;
    logic             abort;
    logic             mode;
    logic [CNT_W-1:0] duration;
    logic [RPT_W-1:0] repeat_count;
    logic             pause;
    logic             enable;
    logic             busy;
    logic             run_done;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] elapsed;
    logic [RPT_W-1:0] run_index;

    modport master (
        output start, abort, mode, duration, repeat_count, pause,
        input  enable, busy, run_done, done, aborted, elapsed, run_index
    );

    modport slave (
        input  start, abort, mode, duration, repeat_count, pause,
        output enable, busy, run_done, done, aborted, elapsed, run_index
    );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: repeated enable-window controller with gaps, abort and progress counters.
// Define RUN_CTRL_PAUSE_EN to let pause freeze the current run.
module run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int RPT_W      = 16,
    parameter int GAP_CYCLES = 2
) (
    input logic          clk,
    input logic          reset,
    run_ctrl_if.slave    bus
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] dur, dur_n, elapsed_n;
    logic [RPT_W-1:0] last, last_n, idx_n;
    logic             cont, cont_n;
    logic [GW-1:0]    gcnt, gcnt_n;
    logic             en_n, rd_n, done_n, ab_n, hold;

`ifdef RUN_CTRL_PAUSE_EN
    assign hold = bus.pause;
`else
    logic unused_pause;
    assign unused_pause = bus.pause;
    assign hold = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        dur_n     = dur;
        last_n    = last;
        cont_n    = cont;
        gcnt_n    = gcnt;
        elapsed_n = bus.elapsed;
        idx_n     = bus.run_index;
        en_n      = 1'b0;
        rd_n      = 1'b0;
        done_n    = 1'b0;
        ab_n      = 1'b0;
        if (state != IDLE && bus.abort) begin
            state_n = IDLE;
            ab_n    = 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.start && !bus.abort) begin
                    if (bus.duration != '0) begin
                        state_n   = RUN;
                        dur_n     = bus.duration;
                        cont_n    = bus.mode;
                        last_n    = bus.repeat_count == '0 ? '0 : bus.repeat_count - 1'b1;
                        elapsed_n = CNT_W'(1);
                        idx_n     = '0;
                        en_n      = 1'b1;
                    end else begin
                        done_n = !bus.mode;
                        rd_n   = bus.mode;
                    end
                end
                RUN: if (bus.elapsed == dur) begin
                    rd_n    = 1'b1;
                    done_n  = !cont && bus.run_index == last;
                    state_n = done_n ? IDLE : GAP;
                    gcnt_n  = '0;
                end else if (!hold) begin
                    en_n      = 1'b1;
                    elapsed_n = bus.elapsed + 1'b1;
                end
                GAP: if (gcnt == GW'(GAP_CYCLES - 1)) begin
                    state_n   = RUN;
                    en_n      = 1'b1;
                    elapsed_n = CNT_W'(1);
                    idx_n     = bus.run_index + 1'b1;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            dur           <= '0;
            last          <= '0;
            cont          <= 1'b0;
            gcnt          <= '0;
            bus.enable    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.run_done  <= 1'b0;
            bus.done      <= 1'b0;
            bus.aborted   <= 1'b0;
            bus.elapsed   <= '0;
            bus.run_index <= '0;
        end else begin
            state         <= state_n;
            dur           <= dur_n;
            last          <= last_n;
            cont          <= cont_n;
            gcnt          <= gcnt_n;
            bus.enable    <= en_n;
            bus.busy      <= state_n != IDLE;
            bus.run_done  <= rd_n;
            bus.done      <= done_n;
            bus.aborted   <= ab_n;
            bus.elapsed   <= elapsed_n;
            bus.run_index <= idx_n;
        end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scoreboard bench; expected per-cycle outputs are queued with each stimulus step.
module tb_run_ctrl;
    localparam int CNT_W = 32;
    localparam int RPT_W = 16;
    localparam int VW    = 5 + CNT_W + RPT_W;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    string tag = "reset";
    logic [VW-1:0] sb[$];

    run_ctrl_if #(.CNT_W(CNT_W), .RPT_W(RPT_W)) bus ();

    run_ctrl #(.CNT_W(CNT_W), .RPT_W(RPT_W), .GAP_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected {enable, busy, run_done, done, aborted, elapsed, run_index} for one upcoming cycle.
    task automatic push(input logic en, input logic bs, input logic rd, input logic dn,
                        input logic ab, input int el, input int ri);
        sb.push_back({en, bs, rd, dn, ab, CNT_W'(el), RPT_W'(ri)});
    endtask

    task automatic cyc();
        logic [VW-1:0] obs, exp;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        obs = {bus.enable, bus.busy, bus.run_done, bus.done, bus.aborted, bus.elapsed, bus.run_index};
        exp = sb.size() > 0 ? sb.pop_front() : ~obs;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed en/bsy/rd/dn/ab=%b el=%0d ri=%0d, expected en/bsy/rd/dn/ab=%b el=%0d ri=%0d",
                   tag, obs[VW-1 -: 5], obs[CNT_W+RPT_W-1 -: CNT_W], obs[RPT_W-1:0],
                   exp[VW-1 -: 5], exp[CNT_W+RPT_W-1 -: CNT_W], exp[RPT_W-1:0]);
        end
    endtask

    task automatic go(input logic m, input int d, input int r);
        bus.mode         = m;
        bus.duration     = CNT_W'(d);
        bus.repeat_count = RPT_W'(r);
        bus.start        = 1'b1;
    endtask

    task automatic win(input int d, input int idx);
        for (int i = 1; i <= d; i++) begin
            push(1, 1, 0, 0, 0, i, idx);
            cyc();
        end
    endtask

    task automatic gap(input int d, input int idx);
        push(0, 1, 1, 0, 0, d, idx);
        cyc();
        push(0, 1, 0, 0, 0, d, idx);
        cyc();
    endtask

    task automatic fin(input int d, input int idx);
        push(0, 0, 1, 1, 0, d, idx);
        cyc();
        push(0, 0, 0, 0, 0, d, idx);
        cyc();
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.mode         = 1'b0;
        bus.duration     = '0;
        bus.repeat_count = '0;
        bus.pause        = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0);
        cyc();
        push(0, 0, 0, 0, 0, 0, 0);
        cyc();
        reset = 1'b0;

        tag = "single";
        go(0, 5, 1);
        win(5, 0);
        fin(5, 0);

        tag = "repeat";
        go(0, 3, 3);
        win(3, 0);
        gap(3, 0);
        win(3, 1);
        gap(3, 1);
        win(3, 2);
        fin(3, 2);

        tag = "zero_dur";
        go(0, 0, 2);
        push(0, 0, 0, 1, 0, 3, 2);
        cyc();
        push(0, 0, 0, 0, 0, 3, 2);
        cyc();

        tag = "zero_rpt";
        go(0, 4, 0);
        win(4, 0);
        fin(4, 0);

        tag = "abort_run";
        go(0, 10, 1);
        win(4, 0);
        bus.abort = 1'b1;
        push(0, 0, 0, 0, 1, 4, 0);
        cyc();
        push(0, 0, 0, 0, 0, 4, 0);
        cyc();

        tag = "abort_start";
        go(0, 3, 1);
        bus.abort = 1'b1;
        push(0, 0, 0, 0, 0, 4, 0);
        cyc();
        push(0, 0, 0, 0, 0, 4, 0);
        cyc();

        tag = "abort_last";
        go(0, 2, 1);
        win(2, 0);
        bus.abort = 1'b1;
        push(0, 0, 0, 0, 1, 2, 0);
        cyc();
        push(0, 0, 0, 0, 0, 2, 0);
        cyc();

        tag = "continuous";
        go(1, 2, 1);
        push(1, 1, 0, 0, 0, 1, 0);
        cyc();
        bus.mode     = 1'b0;
        bus.duration = CNT_W'(7);
        push(1, 1, 0, 0, 0, 2, 0);
        cyc();
        gap(2, 0);
        push(1, 1, 0, 0, 0, 1, 1);
        cyc();
        bus.start = 1'b1;
        push(1, 1, 0, 0, 0, 2, 1);
        cyc();
        gap(2, 1);
        win(2, 2);
        tag = "abort_gap";
        push(0, 1, 1, 0, 0, 2, 2);
        cyc();
        bus.abort = 1'b1;
        push(0, 0, 0, 0, 1, 2, 2);
        cyc();

        tag = "zero_cont";
        go(1, 0, 1);
        push(0, 0, 1, 0, 0, 2, 2);
        cyc();
        push(0, 0, 0, 0, 0, 2, 2);
        cyc();

        tag = "reset_mid";
        go(0, 5, 2);
        win(2, 0);
        reset = 1'b1;
        push(0, 0, 0, 0, 0, 0, 0);
        cyc();
        reset = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0);
        cyc();

        tag = "pause";
        go(0, 6, 1);
        win(2, 0);
        bus.pause = 1'b1;
`ifdef RUN_CTRL_PAUSE_EN
        for (int i = 0; i < 3; i++) begin
            push(0, 1, 0, 0, 0, 2, 0);
            cyc();
        end
        bus.pause = 1'b0;
        for (int i = 3; i <= 6; i++) begin
            push(1, 1, 0, 0, 0, i, 0);
            cyc();
        end
`else
        for (int i = 3; i <= 5; i++) begin
            push(1, 1, 0, 0, 0, i, 0);
            cyc();
        end
        bus.pause = 1'b0;
        push(1, 1, 0, 0, 0, 6, 0);
        cyc();
`endif
        fin(6, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
